alu_result_serializer: RTL and testbench

- Consumer-side end of the ALU result interface. Accepts registered ALU results (a data word qualified by a one-cycle flag) and buffers them in a small FIFO.
- Each word is emitted as a byte stream, LSB byte first, over a valid/ready handshake toward a UART transmitter or host link.
- Sits between the ALU output mux and the byte-wide transmit path.

---
 rtl/alu_result_serializer.sv | 152 +++++++++++++++
 tb/tb_alu_result_serializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// Buffers ALU result words in a small FIFO and streams each word out LSB byte first
// over a valid/ready byte handshake, with overflow reporting when the buffer is full.
module alu_result_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RES_DATA,
    input  logic                  RES_VALID,
    output logic [BYTE_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  FIFO_FULL,
    output logic                  OVERFLOW,
    output logic                  BUSY
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;

    logic fifo_empty;
    logic handshake;
    logic last_byte;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign handshake  = (state_q == SEND) && TX_READY;
    assign last_byte  = (byte_cnt_q == LAST_BYTE);

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a word.
    assign push = RES_VALID && (count_q != DEPTH_C);
    assign pop  = !fifo_empty && ((state_q == IDLE) || (handshake && last_byte));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == DEPTH_C);
        overflow_d = RES_VALID && (count_q == DEPTH_C);
    end

    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        if (pop) begin
            shift_d    = mem_q[rd_ptr_q];
            byte_cnt_d = '0;
        end else if (handshake && !last_byte) begin
            shift_d    = shift_q >> BYTE_WIDTH;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end
    end

    // Storage carries no reset; only entries below count_q are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= RES_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake && last_byte && fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        TX_VALID  = 1'b0;
        TX_DATA   = '0;
        if (state_q == SEND) begin
            TX_VALID = 1'b1;
            TX_DATA  = shift_q[BYTE_WIDTH-1:0];
        end
        BUSY      = (state_q == SEND) || !fifo_empty;
        FIFO_FULL = full_q;
        OVERFLOW  = overflow_q;
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: reset, single word, backpressure,
// back-to-back words, overflow, mid-word reset and a randomized wrap-around run.
module tb_alu_result_serializer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] RES_DATA;
    logic        RES_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        FIFO_FULL;
    logic        OVERFLOW;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    alu_result_serializer #(
        .DATA_WIDTH(16),
        .BYTE_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RES_DATA (RES_DATA),
        .RES_VALID(RES_VALID),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .FIFO_FULL(FIFO_FULL),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; RES_VALID = 1'b0; RES_DATA = '0; TX_READY = 1'b0;
        tick();
        checks++;
        if (TX_VALID !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b expected 0", TX_VALID); end
        checks++;
        if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", TX_DATA); end
        checks++;
        if ({FIFO_FULL, OVERFLOW, BUSY} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got full/ovf/busy=%b expected 000", {FIFO_FULL, OVERFLOW, BUSY});
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        logic ovf_seen;
        ovf_seen  = 1'b0;
        TX_READY  = 1'b1;
        RES_DATA  = 16'hA55A;
        RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        ovf_seen |= OVERFLOW;
        checks++;
        if (TX_VALID !== 1'b0) begin errors++; $display("FAIL single_n1_valid: got %0b expected 0", TX_VALID); end
        tick();
        ovf_seen |= OVERFLOW;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin
            errors++; $display("FAIL single_byte0: got valid=%0b data=%0h expected valid=1 data=5a", TX_VALID, TX_DATA);
        end
        tick();
        ovf_seen |= OVERFLOW;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) begin
            errors++; $display("FAIL single_byte1: got valid=%0b data=%0h expected valid=1 data=a5", TX_VALID, TX_DATA);
        end
        tick();
        ovf_seen |= OVERFLOW;
        checks++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL single_drained: got valid=%0b busy=%0b expected 0 0", TX_VALID, BUSY);
        end
        checks++;
        if (ovf_seen !== 1'b0) begin errors++; $display("FAIL single_overflow: got %0b expected 0", ovf_seen); end
    endtask

    task automatic test_backpressure();
        TX_READY  = 1'b0;
        RES_DATA  = 16'h1234;
        RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
                errors++; $display("FAIL bp_hold_%0d: got valid=%0b data=%0h expected valid=1 data=34", i, TX_VALID, TX_DATA);
            end
            tick();
        end
        TX_READY = 1'b1;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'h34) begin
            errors++; $display("FAIL bp_release: got valid=%0b data=%0h expected valid=1 data=34", TX_VALID, TX_DATA);
        end
        tick();
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'h12) begin
            errors++; $display("FAIL bp_byte1: got valid=%0b data=%0h expected valid=1 data=12", TX_VALID, TX_DATA);
        end
        tick();
        checks++;
        if (TX_VALID !== 1'b0) begin errors++; $display("FAIL bp_end: got valid=%0b expected 0", TX_VALID); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [7:0]  exp   [6];
        words = '{16'h0102, 16'h0304, 16'h0506};
        exp   = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
        TX_READY = 1'b1;
        for (int c = 0; c < 9; c++) begin
            RES_VALID = (c < 3);
            RES_DATA  = (c < 3) ? words[c] : 16'h0000;
            if (c >= 2 && c < 8) begin
                checks++;
                if (TX_VALID !== 1'b1 || TX_DATA !== exp[c-2]) begin
                    errors++; $display("FAIL b2b_byte%0d: got valid=%0b data=%0h expected valid=1 data=%0h", c-2, TX_VALID, TX_DATA, exp[c-2]);
                end
            end
            if (c == 8) begin
                checks++;
                if (TX_VALID !== 1'b0) begin errors++; $display("FAIL b2b_end: got valid=%0b expected 0", TX_VALID); end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        int          n;
        int          cyc;
        logic        ovf_late;
        logic [15:0] exp_word;
        logic [7:0]  exp_byte;
        TX_READY = 1'b0;
        for (int c = 0; c < 8; c++) begin
            RES_VALID = (c < 6);
            RES_DATA  = 16'(c + 1);
            if (c == 4) begin
                checks++;
                if (FIFO_FULL !== 1'b0) begin errors++; $display("FAIL ovf_full_early: got %0b expected 0", FIFO_FULL); end
            end
            if (c == 5) begin
                checks++;
                if (FIFO_FULL !== 1'b1 || OVERFLOW !== 1'b0) begin
                    errors++; $display("FAIL ovf_full: got full=%0b ovf=%0b expected full=1 ovf=0", FIFO_FULL, OVERFLOW);
                end
            end
            if (c == 6) begin
                checks++;
                if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b expected 1", OVERFLOW); end
            end
            if (c == 7) begin
                checks++;
                if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %0b expected 0", OVERFLOW); end
            end
            tick();
        end
        TX_READY = 1'b1;
        n        = 0;
        cyc      = 0;
        ovf_late = 1'b0;
        while (n < 10 && cyc < 100) begin
            ovf_late |= OVERFLOW;
            if (TX_VALID) begin
                exp_word = 16'(n / 2 + 1);
                exp_byte = (n % 2 == 1) ? exp_word[15:8] : exp_word[7:0];
                checks++;
                if (TX_DATA !== exp_byte) begin
                    errors++; $display("FAIL ovf_drain_byte%0d: got %0h expected %0h", n, TX_DATA, exp_byte);
                end
                n++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (n != 10) begin errors++; $display("FAIL ovf_drain_count: got %0d bytes expected 10", n); end
        checks++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || ovf_late !== 1'b0) begin
            errors++; $display("FAIL ovf_drain_end: got valid=%0b busy=%0b ovf=%0b expected 0 0 0", TX_VALID, BUSY, ovf_late);
        end
    endtask

    task automatic test_reset_mid_word();
        TX_READY  = 1'b0;
        RES_DATA  = 16'hBEEF;
        RES_VALID = 1'b1;
        tick();
        RES_DATA  = 16'h1111;
        tick();
        RES_DATA  = 16'h2222;
        TX_READY  = 1'b1;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'hEF) begin
            errors++; $display("FAIL rst_byte0: got valid=%0b data=%0h expected valid=1 data=ef", TX_VALID, TX_DATA);
        end
        tick();
        RES_VALID = 1'b0;
        TX_READY  = 1'b0;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'hBE) begin
            errors++; $display("FAIL rst_byte1_pending: got valid=%0b data=%0h expected valid=1 data=be", TX_VALID, TX_DATA);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({TX_VALID, FIFO_FULL, OVERFLOW, BUSY} !== 4'b0000 || TX_DATA !== 8'h00) begin
            errors++; $display("FAIL rst_async: got valid/full/ovf/busy=%b data=%0h expected 0000 00", {TX_VALID, FIFO_FULL, OVERFLOW, BUSY}, TX_DATA);
        end
        tick();
        tick();
        RST      = 1'b1;
        TX_READY = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin
                errors++; $display("FAIL rst_quiet_%0d: got valid=%0b busy=%0b expected 0 0", i, TX_VALID, BUSY);
            end
            tick();
        end
        RES_DATA  = 16'h5566;
        RES_VALID = 1'b1;
        tick();
        RES_VALID = 1'b0;
        tick();
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'h66) begin
            errors++; $display("FAIL rst_recover: got valid=%0b data=%0h expected valid=1 data=66", TX_VALID, TX_DATA);
        end
        tick();
        tick();
    endtask

    task automatic test_wraparound();
        logic [7:0]  q [$];
        logic [15:0] w;
        logic [7:0]  exp_byte;
        int          sent;
        int          recv;
        int          cyc;
        logic        ovf_seen;
        sent     = 0;
        recv     = 0;
        cyc      = 0;
        ovf_seen = 1'b0;
        while (recv < 40 && cyc < 2000) begin
            ovf_seen |= OVERFLOW;
            TX_READY  = 1'($urandom_range(0, 1));
            RES_VALID = 1'b0;
            if (sent < 20 && !FIFO_FULL && $urandom_range(0, 2) != 0) begin
                w         = {8'(8'h30 + sent), 8'(8'hC0 + sent)};
                RES_DATA  = w;
                RES_VALID = 1'b1;
                q.push_back(w[7:0]);
                q.push_back(w[15:8]);
                sent++;
            end
            if (TX_VALID && TX_READY) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL wrap_byte%0d: got %0h expected no byte", recv, TX_DATA);
                end else begin
                    exp_byte = q.pop_front();
                    if (TX_DATA !== exp_byte) begin
                        errors++; $display("FAIL wrap_byte%0d: got %0h expected %0h", recv, TX_DATA, exp_byte);
                    end
                end
                recv++;
            end
            tick();
            cyc++;
        end
        RES_VALID = 1'b0;
        checks++;
        if (recv != 40 || sent != 20) begin
            errors++; $display("FAIL wrap_count: got sent=%0d recv=%0d expected 20 40", sent, recv);
        end
        checks++;
        if (ovf_seen !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %0b expected 0", ovf_seen); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_wraparound();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
